// File: rtl/avr_cpu_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : avr_cpu_decode_pipe
//  Purpose  : Registered, handshaked AVR instruction decoder between fetch and
//             execute. Decodes LDI/IN/OUT/MOV/NOP and two-word LDS/STS into
//             one registered micro-op per instruction, with backpressure and
//             flush.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef ALU_OP_MOVE
`define ALU_OP_MOVE 4'd1
`endif

module avr_cpu_decode_pipe #(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int PC_WIDTH        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_opcode,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [3:0]                 alu,
  output logic [4:0]                 r_addr,
  output logic [4:0]                 d_addr,
  output logic [7:0]                 immediate,
  output logic                       use_immediate,
  output logic [5:0]                 io_addr,
  output logic                       io_read,
  output logic                       io_write,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       reg_write,
  output logic                       illegal
);

  localparam logic [3:0] c_ALU_MOVE = `ALU_OP_MOVE;

  // IDLE expects a first word; ADDR expects the LDS/STS address word
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_ADDR = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [3:0]                 alu_q, alu_d;
  logic [4:0]                 r_addr_q, r_addr_d;
  logic [4:0]                 d_addr_q, d_addr_d;
  logic [7:0]                 imm_q, imm_d;
  logic                       use_imm_q, use_imm_d;
  logic [5:0]                 io_addr_q, io_addr_d;
  logic                       io_read_q, io_read_d;
  logic                       io_write_q, io_write_d;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                       mem_read_q, mem_read_d;
  logic                       mem_write_q, mem_write_d;
  logic                       reg_write_q, reg_write_d;
  logic                       illegal_q, illegal_d;

  // Combinational decode of the word on in_opcode (meaningful as a first word)
  logic [4:0] w_dec_r_addr;
  logic [4:0] w_dec_d_addr;
  logic       w_dec_use_imm;
  logic       w_dec_io_read;
  logic       w_dec_io_write;
  logic       w_dec_mem_read;
  logic       w_dec_mem_write;
  logic       w_dec_reg_write;
  logic       w_dec_illegal;
  logic       w_dec_two_word;
  logic       w_accept;
  logic       w_xfer;

  // Ready does not look at in_valid, so fetch can use it without a loop
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid_q && out_ready;

  // Decode the incoming opcode into micro-op fields
  always_comb begin
    w_dec_r_addr    = 5'd0;
    w_dec_d_addr    = 5'd0;
    w_dec_use_imm   = 1'b0;
    w_dec_io_read   = 1'b0;
    w_dec_io_write  = 1'b0;
    w_dec_mem_read  = 1'b0;
    w_dec_mem_write = 1'b0;
    w_dec_reg_write = 1'b0;
    w_dec_illegal   = 1'b0;
    w_dec_two_word  = 1'b0;
    if (in_opcode[15:12] == 4'b1110) begin
      // LDI only reaches the upper register half
      w_dec_d_addr    = {1'b1, in_opcode[7:4]};
      w_dec_use_imm   = 1'b1;
      w_dec_reg_write = 1'b1;
    end else if (in_opcode[15:11] == 5'b10110) begin
      w_dec_r_addr    = in_opcode[8:4];
      w_dec_d_addr    = in_opcode[8:4];
      w_dec_io_read   = 1'b1;
      w_dec_reg_write = 1'b1;
    end else if (in_opcode[15:11] == 5'b10111) begin
      w_dec_r_addr    = in_opcode[8:4];
      w_dec_d_addr    = in_opcode[8:4];
      w_dec_io_write  = 1'b1;
    end else if (in_opcode[15:10] == 6'b001011) begin
      w_dec_r_addr    = {in_opcode[9], in_opcode[3:0]};
      w_dec_d_addr    = in_opcode[8:4];
      w_dec_reg_write = 1'b1;
    end else if (in_opcode == 16'h0000) begin
      w_dec_illegal   = 1'b0;
    end else if ((in_opcode[15:10] == 6'b100100) && (in_opcode[3:0] == 4'b0000)) begin
      // Bit 9 separates STS (store) from LDS (load)
      w_dec_two_word = 1'b1;
      if (in_opcode[9]) begin
        w_dec_r_addr    = in_opcode[8:4];
        w_dec_mem_write = 1'b1;
      end else begin
        w_dec_d_addr    = in_opcode[8:4];
        w_dec_mem_read  = 1'b1;
        w_dec_reg_write = 1'b1;
      end
    end else begin
      w_dec_illegal = 1'b1;
    end
  end

  // State register and micro-op output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_ST_IDLE;
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      alu_q       <= 4'd0;
      r_addr_q    <= 5'd0;
      d_addr_q    <= 5'd0;
      imm_q       <= 8'd0;
      use_imm_q   <= 1'b0;
      io_addr_q   <= 6'd0;
      io_read_q   <= 1'b0;
      io_write_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      r_addr_q    <= r_addr_d;
      d_addr_q    <= d_addr_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      io_addr_q   <= io_addr_d;
      io_read_q   <= io_read_d;
      io_write_q  <= io_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  // Next state: enter ADDR on an accepted LDS/STS first word, leave on its address
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = c_ST_IDLE;
    end else if (w_accept) begin
      case (state_q)
        c_ST_IDLE: if (w_dec_two_word) state_d = c_ST_ADDR;
        c_ST_ADDR: state_d = c_ST_IDLE;
        default:   state_d = c_ST_IDLE;
      endcase
    end
  end

  // Next micro-op: hold unless a first word or an address word is accepted
  always_comb begin
    out_valid_d = out_valid_q && !w_xfer;
    pc_d        = pc_q;
    alu_d       = alu_q;
    r_addr_d    = r_addr_q;
    d_addr_d    = d_addr_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    io_addr_d   = io_addr_q;
    io_read_d   = io_read_q;
    io_write_d  = io_write_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      if (state_q == c_ST_IDLE) begin
        // The first word carries everything except the data address
        pc_d        = in_pc;
        alu_d       = c_ALU_MOVE;
        r_addr_d    = w_dec_r_addr;
        d_addr_d    = w_dec_d_addr;
        imm_d       = {in_opcode[11:8], in_opcode[3:0]};
        use_imm_d   = w_dec_use_imm;
        io_addr_d   = {in_opcode[10:9], in_opcode[3:0]};
        io_read_d   = w_dec_io_read;
        io_write_d  = w_dec_io_write;
        mem_addr_d  = '0;
        mem_read_d  = w_dec_mem_read;
        mem_write_d = w_dec_mem_write;
        reg_write_d = w_dec_reg_write;
        illegal_d   = w_dec_illegal;
        out_valid_d = !w_dec_two_word;
      end else begin
        // Address word: never decoded, only completes the pending LDS/STS
        mem_addr_d  = in_opcode[DATA_ADDR_WIDTH-1:0];
        out_valid_d = 1'b1;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = pc_q;
  assign alu           = alu_q;
  assign r_addr        = r_addr_q;
  assign d_addr        = d_addr_q;
  assign immediate     = imm_q;
  assign use_immediate = use_imm_q;
  assign io_addr       = io_addr_q;
  assign io_read       = io_read_q;
  assign io_write      = io_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign reg_write     = reg_write_q;
  assign illegal       = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_avr_cpu_decode_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_avr_cpu_decode_pipe
//  Purpose  : Scoreboard bench for avr_cpu_decode_pipe; two instances (16-bit
//             and 8-bit data address) share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef ALU_OP_MOVE
`define ALU_OP_MOVE 4'd1
`endif

module tb_avr_cpu_decode_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     = 1'b1;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_opcode = 16'h0;
  logic [15:0] in_pc     = 16'h0;

  logic        a_in_ready, a_out_valid, a_ui, a_ior, a_iow, a_mr, a_mw, a_rw, a_ill;
  logic [15:0] a_out_pc, a_mem;
  logic [3:0]  a_alu;
  logic [4:0]  a_r, a_d;
  logic [7:0]  a_imm;
  logic [5:0]  a_io;

  logic        b_in_ready, b_out_valid, b_ui, b_ior, b_iow, b_mr, b_mw, b_rw, b_ill;
  logic [15:0] b_out_pc;
  logic [7:0]  b_mem;
  logic [3:0]  b_alu;
  logic [4:0]  b_r, b_d;
  logic [7:0]  b_imm;
  logic [5:0]  b_io;

  avr_cpu_decode_pipe #(.DATA_ADDR_WIDTH(16), .PC_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_opcode(in_opcode), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .alu(a_alu), .r_addr(a_r), .d_addr(a_d), .immediate(a_imm),
    .use_immediate(a_ui), .io_addr(a_io), .io_read(a_ior), .io_write(a_iow),
    .mem_addr(a_mem), .mem_read(a_mr), .mem_write(a_mw), .reg_write(a_rw), .illegal(a_ill)
  );

  avr_cpu_decode_pipe #(.DATA_ADDR_WIDTH(8), .PC_WIDTH(16)) u_dut8 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_opcode(in_opcode), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .alu(b_alu), .r_addr(b_r), .d_addr(b_d), .immediate(b_imm),
    .use_immediate(b_ui), .io_addr(b_io), .io_read(b_ior), .io_write(b_iow),
    .mem_addr(b_mem), .mem_read(b_mr), .mem_write(b_mw), .reg_write(b_rw), .illegal(b_ill)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  alu;
    logic [4:0]  r;
    logic [4:0]  d;
    logic [7:0]  imm;
    logic        ui;
    logic [5:0]  io;
    logic        ior;
    logic        iow;
    logic [15:0] mem;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        ill;
  } uop_t;

  uop_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        pending = 1'b0;
  logic [15:0] pend_op, pend_pc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_t act_a();
    return {a_out_pc, a_alu, a_r, a_d, a_imm, a_ui, a_io, a_ior, a_iow, a_mem, a_mr, a_mw, a_rw, a_ill};
  endfunction

  function automatic uop_t act_b();
    return {b_out_pc, b_alu, b_r, b_d, b_imm, b_ui, b_io, b_ior, b_iow, {8'h00, b_mem}, b_mr, b_mw, b_rw, b_ill};
  endfunction

  // Reference decode straight from the instruction-set encodings
  function automatic uop_t decode(input logic [15:0] op, input logic [15:0] pc);
    uop_t u;
    u     = '0;
    u.pc  = pc;
    u.alu = `ALU_OP_MOVE;
    u.imm = {op[11:8], op[3:0]};
    u.io  = {op[10:9], op[3:0]};
    casez (op)
      16'b1110_????_????_????: begin u.d = {1'b1, op[7:4]}; u.ui = 1'b1; u.rw = 1'b1; end
      16'b1011_0???_????_????: begin u.r = op[8:4]; u.d = op[8:4]; u.ior = 1'b1; u.rw = 1'b1; end
      16'b1011_1???_????_????: begin u.r = op[8:4]; u.d = op[8:4]; u.iow = 1'b1; end
      16'b0010_11??_????_????: begin u.r = {op[9], op[3:0]}; u.d = op[8:4]; u.rw = 1'b1; end
      16'b0000_0000_0000_0000: ;
      16'b1001_000?_????_0000: begin u.d = op[8:4]; u.mr = 1'b1; u.rw = 1'b1; end
      16'b1001_001?_????_0000: begin u.r = op[8:4]; u.mw = 1'b1; end
      default:                 u.ill = 1'b1;
    endcase
    return u;
  endfunction

  function automatic logic is_two_word(input logic [15:0] op);
    return (op & 16'hFC0F) == 16'h9000;
  endfunction

  // Model of one accepted word: either completes a pending LDS/STS or starts one
  task automatic model_accept(input logic [15:0] op, input logic [15:0] pc);
    uop_t u;
    if (pending) begin
      u     = decode(pend_op, pend_pc);
      u.mem = op;
      q.push_back(u);
      pending = 1'b0;
    end else if (is_two_word(op)) begin
      pending = 1'b1;
      pend_op = op;
      pend_pc = pc;
    end else begin
      q.push_back(decode(op, pc));
    end
  endtask

  // Monitor: 3ns after the falling edge, before the next rising edge
  initial begin
    uop_t e;
    forever begin
      @(negedge clk);
      #3;
      chk("out_valid_a", a_out_valid, q.size() != 0);
      chk("out_valid_b", b_out_valid, q.size() != 0);
      if (a_out_valid && q.size() != 0) begin
        e = q[0];
        chk("uop_a", act_a(), e);
        e.mem = {8'h00, e.mem[7:0]};
        chk("uop_b", act_b(), e);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // One cycle of stimulus; model update happens after the monitor has sampled
  task automatic cyc(input logic iv, input logic [15:0] op, input logic [15:0] pc,
                     input logic ordy, input logic fl, input logic rs, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = iv;
    in_opcode = op;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #2;
    exp_rdy = !fl && (q.size() == 0 || ordy);
    chk("in_ready_a", a_in_ready, exp_rdy);
    chk("in_ready_b", b_in_ready, exp_rdy);
    #2;
    acc = iv && exp_rdy && !rs;
    if (rs || fl) begin
      q.delete();
      pending = 1'b0;
    end else if (acc) begin
      model_accept(op, pc);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gen();
    logic [31:0] r;
    r = $urandom;
    case (r[31:29])
      3'd0:    return {4'hE, r[11:0]};
      3'd1:    return {5'b10110, r[10:0]};
      3'd2:    return {5'b10111, r[10:0]};
      3'd3:    return {6'b001011, r[9:0]};
      3'd4:    return 16'h0000;
      3'd5,
      3'd6:    return {6'b100100, r[5:0], 4'b0000};
      default: return r[15:0];
    endcase
  endfunction

  initial begin
    logic        acc, iv, ordy, fl, rs;
    logic [15:0] w, pc;

    // Reset
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, acc);
    cyc(1'b1, 16'hE5A3, 16'h0, 1'b1, 1'b0, 1'b1, acc);
    settle();
    chk("reset_out_valid", a_out_valid, 1'b0);
    chk("reset_outputs_a", act_a(), '0);
    chk("reset_outputs_b", act_b(), '0);

    // LDI
    cyc(1'b1, 16'hE5A3, 16'h0010, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("ldi_valid", a_out_valid, 1'b1);
    chk("ldi_d_addr", a_d, 5'd26);
    chk("ldi_imm", a_imm, 8'h53);
    chk("ldi_flags", {a_ui, a_rw}, 2'b11);
    chk("ldi_pc", a_out_pc, 16'h0010);

    // OUT then IN, back to back
    cyc(1'b1, 16'hBB18, 16'h0011, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("out_flags", {a_iow, a_ior, a_rw}, 3'b100);
    chk("out_r_addr", a_r, 5'd17);
    chk("out_io_addr", a_io, 6'h18);
    cyc(1'b1, 16'hB30F, 16'h0012, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("in_flags", {a_ior, a_rw}, 2'b11);
    chk("in_d_addr", a_d, 5'd16);
    chk("in_io_addr", a_io, 6'h1F);

    // LDS: no micro-op after the first word, one after the second
    cyc(1'b1, 16'h9100, 16'h0020, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("lds_first_no_valid", a_out_valid, 1'b0);
    cyc(1'b1, 16'h0123, 16'h0021, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("lds_valid", a_out_valid, 1'b1);
    chk("lds_fields", {a_mr, a_rw, a_d}, {2'b11, 5'd16});
    chk("lds_mem_addr", a_mem, 16'h0123);
    chk("lds_pc", a_out_pc, 16'h0020);

    // STS with truncated address on the narrow instance
    cyc(1'b1, 16'h9330, 16'h0022, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'hBEEF, 16'h0023, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("sts_fields", {a_mw, a_rw, a_r}, {2'b10, 5'd19});
    chk("sts_mem_addr16", a_mem, 16'hBEEF);
    chk("sts_mem_addr8", b_mem, 8'hEF);

    // Backpressure: held output must stay stable and block new words
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'hE5A3, 16'h0030, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'h2C12, 16'h0031, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_no_accept", acc, 1'b0);
    end
    cyc(1'b1, 16'h2C12, 16'h0031, 1'b1, 1'b0, 1'b0, acc);
    chk("bp_release_accept", acc, 1'b1);

    // Flush in ADDR: next word is a first word
    cyc(1'b1, 16'h9100, 16'h0040, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h0055, 16'h0041, 1'b1, 1'b1, 1'b0, acc);
    cyc(1'b1, 16'hE5A3, 16'h0041, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("flush_then_ldi", {a_ui, a_mr, a_d}, {2'b10, 5'd26});

    // Illegal word
    cyc(1'b1, 16'hFFFF, 16'h0042, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("illegal_flag", a_ill, 1'b1);
    chk("illegal_no_flags", {a_mr, a_mw, a_ior, a_iow, a_rw, a_ui}, 6'b0);

    // Reset in ADDR
    cyc(1'b1, 16'h9100, 16'h0043, 1'b1, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h0055, 16'h0044, 1'b1, 1'b0, 1'b1, acc);
    settle();
    chk("rst_addr_valid", a_out_valid, 1'b0);
    chk("rst_addr_outputs", act_a(), '0);
    cyc(1'b1, 16'hE5A3, 16'h0045, 1'b1, 1'b0, 1'b0, acc);
    settle();
    chk("rst_addr_then_ldi", {a_ui, a_mem}, {1'b1, 16'h0000});

    // Random traffic; a word is held until accepted so none is lost
    pc = 16'h0100;
    w  = gen();
    for (int i = 0; i < 800; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 29) == 0);
      rs   = ($urandom_range(0, 199) == 0);
      cyc(iv, w, pc, ordy, fl, rs, acc);
      if (acc) begin
        w  = gen();
        pc = pc + 16'd1;
      end
    end

    // Drain
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
